// File: rtl/cordic_mul.sv
// cordic_mul: iterative linear-rotation CORDIC multiplier, res = x_i * z_i with z_i in Q1.(ACCURANCY-1).
// Define CORDIC_MUL_ROUND_EN to round the shifted multiplicand half-up instead of flooring it.
module cordic_mul #(
  parameter int DWIDTH    = 16,
  parameter int ACCURANCY = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DWIDTH-1:0]    x_i,
  input  logic [ACCURANCY-1:0] z_i,
  input  logic                 req,
  output logic                 busy,
  output logic                 rdy,
  output logic [DWIDTH-1:0]    res
);

  localparam int YW = DWIDTH + 2;
  localparam int ZW = ACCURANCY + 2;
  localparam int CW = $clog2(ACCURANCY) + 1;

  localparam logic signed [YW-1:0] Y_MAX = {3'b000, {(DWIDTH-1){1'b1}}};
  localparam logic signed [YW-1:0] Y_MIN = ~Y_MAX;
  localparam logic signed [YW-1:0] Y_ONE = 1;
  localparam logic signed [ZW-1:0] Z_ONE = 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                   r_state;
  state_t                   w_stateNext;
  logic signed [DWIDTH-1:0] r_xr;
  logic signed [YW-1:0]     r_y;
  logic signed [ZW-1:0]     r_z;
  logic [CW-1:0]            r_cnt;
  logic                     r_rdy;
  logic [DWIDTH-1:0]        r_res;

  logic signed [YW-1:0]     w_xExt;
  logic signed [YW-1:0]     w_xs;
  logic signed [ZW-1:0]     w_zStep;
  logic signed [YW-1:0]     w_yNext;
  logic signed [ZW-1:0]     w_zNext;
  logic                     w_dPos;
  logic                     w_last;
  logic [DWIDTH-1:0]        w_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (req) w_stateNext = ITER;
      ITER:    if (w_last) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // One rotation step: residual z steers the sign of the shifted multiplicand added into y.
  assign w_xExt = {{2{r_xr[DWIDTH-1]}}, r_xr};

  always_comb begin
`ifdef CORDIC_MUL_ROUND_EN
    if (r_cnt == '0) w_xs = w_xExt;
    else             w_xs = (w_xExt + (Y_ONE << (r_cnt - CW'(1)))) >>> r_cnt;
`else
    w_xs = w_xExt >>> r_cnt;
`endif
  end

  assign w_zStep = Z_ONE << (CW'(ACCURANCY - 1) - r_cnt);
  assign w_dPos  = ~r_z[ZW-1];
  assign w_yNext = w_dPos ? (r_y + w_xs) : (r_y - w_xs);
  assign w_zNext = w_dPos ? (r_z - w_zStep) : (r_z + w_zStep);
  assign w_last  = (r_cnt == CW'(ACCURANCY - 1));

  always_comb begin
    if (w_yNext > Y_MAX)      w_sat = Y_MAX[DWIDTH-1:0];
    else if (w_yNext < Y_MIN) w_sat = Y_MIN[DWIDTH-1:0];
    else                      w_sat = w_yNext[DWIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xr  <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_cnt <= '0;
      r_rdy <= 1'b0;
      r_res <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_xr  <= x_i;
            r_y   <= '0;
            r_z   <= {{2{z_i[ACCURANCY-1]}}, z_i};
            r_cnt <= '0;
          end
        end
        ITER: begin
          r_y   <= w_yNext;
          r_z   <= w_zNext;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_res <= w_sat;
            r_rdy <= 1'b1;
          end
        end
        DONE:    r_rdy <= 1'b0;
        default: r_rdy <= 1'b0;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign rdy  = r_rdy;
  assign res  = r_res;

endmodule
